// File: rtl/button_conditioner.sv
// Purpose: synchronize, debounce and edge-detect the two raw paddle buttons for the game logic.
// Latency: a clean raw transition reaches the outputs DEBOUNCE_CYCLES+2 clk25 edges after first being sampled.
// Backpressure: none; outputs are free-running levels and one-cycle press pulses.
// Optional build macro BUTTON_AUTOREPEAT_EN adds hold-to-repeat press pulses.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18,
  parameter int REPEAT_DELAY    = 12500000,
  parameter int REPEAT_PERIOD   = 2500000
) (
  input  logic clk25,
  input  logic rst_n,
  input  logic button_left_raw,
  input  logic button_right_raw,
  output logic button_left,
  output logic button_right,
  output logic left_press,
  output logic right_press
);

  // Counter saturates at this value; it is compared, never exceeded, so it cannot wrap.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Index 0 is the left button, index 1 the right button.
  logic [1:0]       raw;
  logic [1:0]       sync1;
  logic [1:0]       sync2;
  logic [1:0]       stable;
  logic [1:0]       stable_nxt;
  logic [1:0]       rise;
  logic [1:0]       press_nxt;
  logic [CNT_W-1:0] cnt     [2];
  logic [CNT_W-1:0] cnt_nxt [2];

  assign raw = {button_right_raw, button_left_raw};

  // Two-flop synchronizer per button, no logic between the stages.
  always_ff @(posedge clk25) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Debounce: accept a new level only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      stable_nxt[i] = stable[i];
      cnt_nxt[i]    = '0;
      if (sync2[i] != stable[i]) begin
        if (cnt[i] == CNT_MAX) begin
          stable_nxt[i] = sync2[i];
        end else begin
          cnt_nxt[i] = cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign rise = stable_nxt & ~stable;

`ifdef BUTTON_AUTOREPEAT_EN
  // Hold counter restarts at 0 on the press edge; after firing at REPEAT_DELAY it is rewound
  // so it reaches REPEAT_DELAY again REPEAT_PERIOD cycles later (assumes PERIOD <= DELAY).
  localparam int                HOLD_W    = $clog2(REPEAT_DELAY + 1);
  localparam logic [HOLD_W-1:0] HOLD_FIRE = HOLD_W'(REPEAT_DELAY);
  localparam logic [HOLD_W-1:0] HOLD_WRAP = HOLD_W'(REPEAT_DELAY - REPEAT_PERIOD + 1);

  logic [HOLD_W-1:0] hold     [2];
  logic [HOLD_W-1:0] hold_nxt [2];

  // Press pulse on the accepted rising edge plus periodic repeats while the level stays high.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      hold_nxt[i]  = '0;
      press_nxt[i] = rise[i];
      if (stable[i] && stable_nxt[i]) begin
        hold_nxt[i] = (hold[i] == HOLD_FIRE) ? HOLD_WRAP : hold[i] + HOLD_W'(1);
        if (hold_nxt[i] == HOLD_FIRE) begin
          press_nxt[i] = 1'b1;
        end
      end
    end
  end

  // Hold counters clear in reset and whenever the debounced level is low.
  always_ff @(posedge clk25) begin
    if (!rst_n) begin
      hold[0] <= '0;
      hold[1] <= '0;
    end else begin
      hold[0] <= hold_nxt[0];
      hold[1] <= hold_nxt[1];
    end
  end
`else
  // Repeat timing has no effect in this build; the parameters stay for a uniform interface.
  if (REPEAT_DELAY < 0 || REPEAT_PERIOD < 0) begin : g_repeat_unused
  end

  assign press_nxt = rise;
`endif

  // Debounce state and outputs; levels are conflict-masked, press pulses are not.
  always_ff @(posedge clk25) begin
    if (!rst_n) begin
      stable       <= '0;
      cnt[0]       <= '0;
      cnt[1]       <= '0;
      button_left  <= 1'b0;
      button_right <= 1'b0;
      left_press   <= 1'b0;
      right_press  <= 1'b0;
    end else begin
      stable       <= stable_nxt;
      cnt[0]       <= cnt_nxt[0];
      cnt[1]       <= cnt_nxt[1];
      button_left  <= stable_nxt[0] & ~stable_nxt[1];
      button_right <= stable_nxt[1] & ~stable_nxt[0];
      left_press   <= press_nxt[0];
      right_press  <= press_nxt[1];
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4.
// Expected output vectors {button_left, button_right, left_press, right_press} are queued per edge
// as each phase is scheduled, then popped and compared 1 time unit after that edge.
module tb_button_conditioner;

  localparam int DEB        = 4;
  localparam int REP_DELAY  = 10;
  localparam int REP_PERIOD = 5;

  logic clk25;
  logic rst_n;
  logic button_left_raw;
  logic button_right_raw;
  logic button_left;
  logic button_right;
  logic left_press;
  logic right_press;
  logic [3:0] outs;

  typedef struct {
    int         at_cyc;
    logic [3:0] val;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int   cyc;
  int   checks;
  int   failures;

  button_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (4),
    .REPEAT_DELAY   (REP_DELAY),
    .REPEAT_PERIOD  (REP_PERIOD)
  ) dut (
    .clk25           (clk25),
    .rst_n           (rst_n),
    .button_left_raw (button_left_raw),
    .button_right_raw(button_right_raw),
    .button_left     (button_left),
    .button_right    (button_right),
    .left_press      (left_press),
    .right_press     (right_press)
  );

  assign outs = {button_left, button_right, left_press, right_press};

  initial clk25 = 1'b0;
  always #20 clk25 = ~clk25;

  // Whether right_press is expected at a given offset from the accepted press edge.
  function automatic logic rep_pulse(input int off);
`ifdef BUTTON_AUTOREPEAT_EN
    return (off == 0) || (off >= REP_DELAY && ((off - REP_DELAY) % REP_PERIOD) == 0);
`else
    return (off == 0);
`endif
  endfunction

  task automatic expect_at(input int c, input logic [3:0] v, input string tag);
    exp_t e;
    e.at_cyc = c;
    e.val    = v;
    e.tag    = tag;
    exp_q.push_back(e);
  endtask

  task automatic expect_span(input int first, input int last, input logic [3:0] v, input string tag);
    for (int c = first; c <= last; c++) expect_at(c, v, tag);
  endtask

  // Drive inputs for one edge, then compare every expectation queued for that edge.
  task automatic tick(input logic rn, input logic rl, input logic rr);
    exp_t e;
    rst_n            = rn;
    button_left_raw  = rl;
    button_right_raw = rr;
    @(posedge clk25);
    cyc++;
    #1;
    while (exp_q.size() > 0 && exp_q[0].at_cyc <= cyc) begin
      e = exp_q.pop_front();
      checks++;
      assert (outs === e.val && e.at_cyc == cyc) else begin
        failures++;
        $error("FAIL %s edge=%0d observed=%b expected=%b (l r lp rp)", e.tag, e.at_cyc, outs, e.val);
      end
    end
  endtask

  task automatic run(input logic rn, input logic rl, input logic rr, input int n);
    repeat (n) tick(rn, rl, rr);
  endtask

  initial begin
    int b;
    int a;
    cyc      = 0;
    checks   = 0;
    failures = 0;

    // 1: left held through reset, then a full debounce after release
    expect_span(1, 3, 4'b0000, "reset_hold");
    run(1'b0, 1'b1, 1'b0, 3);
    b = cyc;
    expect_span(b + 1, b + 5, 4'b0000, "t1_wait");
    expect_at(b + 6, 4'b1010, "t1_rise");
    expect_span(b + 7, b + 10, 4'b1000, "t1_hold");
    run(1'b1, 1'b1, 1'b0, 10);

    // release left: level falls after debounce, no pulse on release
    b = cyc;
    expect_span(b + 1, b + 5, 4'b1000, "t2_rel_wait");
    expect_span(b + 6, b + 8, 4'b0000, "t2_rel_done");
    run(1'b1, 1'b0, 1'b0, 8);

    // 2: bounce 1,0,1,0 (3 cycles each, one short of acceptance), then steady 1
    b = cyc;
    expect_span(b + 1, b + 17, 4'b0000, "t2_bounce");
    expect_at(b + 18, 4'b1010, "t2_rise");
    expect_at(b + 19, 4'b1000, "t2_one_pulse");
    run(1'b1, 1'b1, 1'b0, 3);
    run(1'b1, 1'b0, 1'b0, 3);
    run(1'b1, 1'b1, 1'b0, 3);
    run(1'b1, 1'b0, 1'b0, 3);
    run(1'b1, 1'b1, 1'b0, 7);

    // release left before the conflict test
    b = cyc;
    expect_span(b + 1, b + 5, 4'b1000, "t3_pre_wait");
    expect_span(b + 6, b + 7, 4'b0000, "t3_pre_done");
    run(1'b1, 1'b0, 1'b0, 7);

    // 3: both pressed together -> both pulse once, levels masked
    b = cyc;
    expect_span(b + 1, b + 5, 4'b0000, "t3_both_wait");
    expect_at(b + 6, 4'b0011, "t3_both_press");
    expect_span(b + 7, b + 10, 4'b0000, "t3_both_held");
    run(1'b1, 1'b1, 1'b1, 10);

    // release right -> left level appears without a new left_press
    b = cyc;
    expect_span(b + 1, b + 5, 4'b0000, "t3_relr_wait");
    expect_span(b + 6, b + 8, 4'b1000, "t3_left_only");
    run(1'b1, 1'b1, 1'b0, 8);

    // press right while left held -> right pulses, both levels masked
    b = cyc;
    expect_span(b + 1, b + 5, 4'b1000, "t3_repress_wait");
    expect_at(b + 6, 4'b0001, "t3_right_pulse");
    expect_span(b + 7, b + 8, 4'b0000, "t3_masked");
    run(1'b1, 1'b1, 1'b1, 8);

    // release both
    b = cyc;
    expect_span(b + 1, b + 8, 4'b0000, "t3_rel_both");
    run(1'b1, 1'b0, 1'b0, 8);

    // 4: reset for one cycle at count=2 discards the partial debounce
    b = cyc;
    expect_span(b + 1, b + 10, 4'b0000, "t4_wait");
    expect_at(b + 11, 4'b1010, "t4_rise");
    expect_at(b + 12, 4'b1000, "t4_hold");
    run(1'b1, 1'b1, 1'b0, 4);
    run(1'b0, 1'b1, 1'b0, 1);
    run(1'b1, 1'b1, 1'b0, 7);

    // release left
    b = cyc;
    expect_span(b + 1, b + 5, 4'b1000, "t5_pre_wait");
    expect_span(b + 6, b + 7, 4'b0000, "t5_pre_done");
    run(1'b1, 1'b0, 1'b0, 7);

    // 5: hold right for 30 cycles after acceptance; repeats only in the auto-repeat build
    b = cyc;
    a = b + 6;
    expect_span(b + 1, b + 5, 4'b0000, "t5_wait");
    for (int off = 0; off < 30; off++) begin
      expect_at(a + off, {3'b010, rep_pulse(off)}, "t5_hold");
    end
    expect_span(a + 30, a + 40, 4'b0000, "t5_released");
    run(1'b1, 1'b0, 1'b1, 30);
    run(1'b1, 1'b0, 1'b0, 16);

    checks++;
    assert (exp_q.size() == 0) else begin
      failures++;
      $error("FAIL queue_drained observed=%0d expected=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
